// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads words from instruction memory
// over req/ack, and holds the fetched word for the opcode controller.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         op_code,
   output logic [ADDR_W-1:0]  pc_plus1,
   output logic               instr_valid,
   output logic               illegal_op,
   output logic [15:0]        fetch_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;

   // One bit per opcode; set bits are the opcodes the controller implements.
   localparam logic [15:0] LEGAL_OPS = 16'hC5C7;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] addr_q;
   logic              squash;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         addr_q      <= RESET_PC;
         instr       <= '0;
         pc_plus1    <= '0;
         fetch_count <= '0;
         squash      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_REQ;
               if (redirect) begin
                  pc     <= redirect_pc;
                  addr_q <= redirect_pc;
               end else begin
                  addr_q <= pc;
               end
            end
            S_REQ: begin
               if (imem_ack) begin
                  // A redirect seen during or at the end of the access makes the word stale.
                  if (squash || redirect) begin
                     squash <= 1'b0;
                     if (redirect) pc <= redirect_pc;
                     state  <= S_IDLE;
                  end else begin
                     instr    <= imem_rdata;
                     pc_plus1 <= addr_q + 1'b1;
                     pc       <= addr_q + 1'b1;
                     state    <= S_VALID;
                  end
               end else if (redirect) begin
                  pc     <= redirect_pc;
                  squash <= 1'b1;
               end
            end
            S_VALID: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= S_IDLE;
               end else if (!stall) begin
                  fetch_count <= fetch_count + 16'd1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign imem_req    = (state == S_REQ);
   assign imem_addr   = addr_q;
   assign instr_valid = (state == S_VALID);
   assign op_code     = instr[INSTR_W-1:INSTR_W-4];
   assign illegal_op  = instr_valid && !LEGAL_OPS[op_code];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random stall/redirect/latency
// traffic, checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;
   localparam int AW = 16;
   localparam int IW = 16;

   logic          clk = 1'b0, rst_n = 1'b1;
   logic          imem_req, imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0;
   logic [AW-1:0] imem_addr, redirect_pc = '0, pc_plus1;
   logic [IW-1:0] imem_rdata = '0, instr;
   logic [3:0]    op_code;
   logic          instr_valid, illegal_op;
   logic [15:0]   fetch_count;

   instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
      .op_code(op_code), .pc_plus1(pc_plus1), .instr_valid(instr_valid),
      .illegal_op(illegal_op), .fetch_count(fetch_count));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [15:0] mem [0:65535];

   // Model: next fetch address, address of the outstanding fetch, last accepted word.
   logic        m_req, m_valid, stale, spur_ack;
   logic [15:0] m_pc, m_req_addr, m_instr, m_pp1, m_cnt;
   int          wcnt, lat_force;

   function automatic logic legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd10, 4'd14, 4'd15};
   endfunction

   task automatic model_reset();
      m_req = 0; m_valid = 0; stale = 0; m_pc = 0; m_req_addr = 0;
      m_instr = 0; m_pp1 = 0; m_cnt = 0; wcnt = -1;
   endtask

   // Drive one cycle of inputs (plus memory response), predict, then check at negedge.
   task automatic step(input logic s, input logic r, input logic [15:0] rpc);
      logic nreq, nval;
      stall = s; redirect = r; redirect_pc = rpc;
      if (imem_req) begin
         if (wcnt < 0) wcnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
         if (wcnt == 0) begin
            imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wcnt = -1;
         end else begin
            imem_ack = 1'b0; imem_rdata = 16'($urandom); wcnt--;
         end
      end else begin
         wcnt = -1; imem_ack = spur_ack; imem_rdata = 16'($urandom);
      end

      nreq = 0; nval = 0;
      if (m_req) begin
         if (imem_ack) begin
            if (stale || r) begin
               stale = 0;
               if (r) m_pc = rpc;
            end else begin
               nval = 1; m_instr = mem[m_req_addr];
               m_pp1 = m_req_addr + 16'd1; m_pc = m_pp1;
            end
         end else begin
            nreq = 1;
            if (r) begin stale = 1; m_pc = rpc; end
         end
      end else if (m_valid) begin
         if (r) m_pc = rpc;
         else if (s) nval = 1;
         else m_cnt++;
      end else begin
         nreq = 1;
         if (r) m_pc = rpc;
         m_req_addr = m_pc;
      end

      @(negedge clk);
      m_req = nreq; m_valid = nval;
      chk("req", imem_req, m_req);
      chk("valid", instr_valid, m_valid);
      if (m_req) chk("addr", imem_addr, m_req_addr);
      chk("instr", instr, m_instr);
      chk("op", op_code, m_instr[15:12]);
      chk("pp1", pc_plus1, m_pp1);
      chk("count", fetch_count, m_cnt);
      chk("illegal", illegal_op, m_valid && !legal(m_instr[15:12]));
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      mem[16'h0000] = 16'h2123; mem[16'h0001] = 16'h8456;
      mem[16'h0010] = 16'h3000; mem[16'h0011] = 16'hF123;
      lat_force = 0; spur_ack = 0; model_reset();

      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst req", imem_req, 0);       chk("rst valid", instr_valid, 0);
      chk("rst illegal", illegal_op, 0); chk("rst instr", instr, 0);
      chk("rst pp1", pc_plus1, 0);       chk("rst count", fetch_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // First fetch, zero-wait memory
      step(0, 0, 0); chk("t1 req", imem_req, 1); chk("t1 addr", imem_addr, 16'h0000);
      step(0, 0, 0); chk("t1 instr", instr, 16'h2123); chk("t1 op", op_code, 4'd2);
      chk("t1 valid", instr_valid, 1); chk("t1 pp1", pc_plus1, 16'h0001);
      step(0, 0, 0); chk("t1 drop", instr_valid, 0); chk("t1 count", fetch_count, 1);
      step(0, 0, 0); chk("t1 next addr", imem_addr, 16'h0001);

      // Hold under stall
      step(1, 0, 0); chk("t2 instr", instr, 16'h8456);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         chk("t2 hold valid", instr_valid, 1); chk("t2 hold op", op_code, 4'd8);
         chk("t2 no req", imem_req, 0);        chk("t2 hold count", fetch_count, 1);
      end
      step(0, 0, 0); chk("t2 count", fetch_count, 2);

      // Redirect while a slow access is pending
      lat_force = 4;
      step(0, 0, 0); chk("t3 addr", imem_addr, 16'h0002);
      for (int i = 0; i < 4; i++) begin
         step(0, i == 1, 16'h0040);
         chk("t3 addr held", imem_addr, 16'h0002); chk("t3 no valid", instr_valid, 0);
      end
      step(0, 0, 0); chk("t3 discard", instr_valid, 0); chk("t3 gap", imem_req, 0);
      step(0, 0, 0); chk("t3 new addr", imem_addr, 16'h0040);

      // Redirect beats stall in the valid state
      lat_force = 0;
      step(0, 0, 0);
      step(1, 1, 16'h0010); chk("t4 drop", instr_valid, 0); chk("t4 count", fetch_count, 2);
      step(0, 0, 0); chk("t4 addr", imem_addr, 16'h0010);

      // Illegal / legal opcode decode
      step(0, 0, 0); chk("t5 op", op_code, 4'd3); chk("t5 illegal", illegal_op, 1);
      step(0, 0, 0); chk("t5 count", fetch_count, 3);
      step(0, 0, 0);
      step(1, 0, 0); chk("t5 instr", instr, 16'hF123); chk("t5 legal", illegal_op, 0);

      // PC wrap at the top of the address space
      step(1, 1, 16'hFFFF);
      step(0, 0, 0); chk("t6 addr", imem_addr, 16'hFFFF);
      step(0, 0, 0); chk("t6 pp1", pc_plus1, 16'h0000);
      step(0, 0, 0); chk("t6 count", fetch_count, 4);
      step(0, 0, 0); chk("t6 wrap addr", imem_addr, 16'h0000);

      // Async reset in the middle of a pending access
      lat_force = 3;
      step(0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar req", imem_req, 0); chk("ar valid", instr_valid, 0);
      chk("ar count", fetch_count, 0); chk("ar instr", instr, 0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1; spur_ack = 1;
      step(0, 0, 0); chk("ar refetch", imem_addr, 16'h0000);
      spur_ack = 0;

      // Random traffic
      lat_force = -1;
      for (int i = 0; i < 3000; i++) begin
         spur_ack = ($urandom_range(0, 7) == 0);
         step(1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
              ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
